// File: rtl/pio_clock_display_sequencer.sv
// mm:ss BCD time counter that mirrors each changed digit to its 7-segment PIO
// through a single Avalon-MM write master, one digit per transfer.
module pio_clock_display_sequencer #(
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                STRIDE         = 16,
  parameter bit                SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              run,
  input  logic              clear,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              overrun
);

  // state | meaning
  // IDLE  | no transfer on the bus; launches the lowest dirty digit
  // WRITE | write beat presented, held until avm_waitrequest drops
  typedef enum logic {IDLE, WRITE} state_t;

  state_t     state;
  logic [3:0] digit     [4];
  logic [3:0] digit_nxt [4];
  logic [3:0] dirty;
  logic [3:0] dirty_nxt;
  logic [3:0] changed;
  logic [3:0] sel_mask;
  logic [1:0] sel_idx;
  logic       count_en;
  logic       launch;
  logic       carry;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    logic [7:0] raw;
    case (v)
      4'd0:    raw = 8'h3F;
      4'd1:    raw = 8'h06;
      4'd2:    raw = 8'h5B;
      4'd3:    raw = 8'h4F;
      4'd4:    raw = 8'h66;
      4'd5:    raw = 8'h6D;
      4'd6:    raw = 8'h7D;
      4'd7:    raw = 8'h07;
      4'd8:    raw = 8'h7F;
      4'd9:    raw = 8'h6F;
      default: raw = 8'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  assign count_en = tick & run & ~clear;

  // Ripple carry: even digits wrap at 9, odd (tens) digits wrap at 5.
  always_comb begin
    carry = count_en;
    for (int i = 0; i < 4; i++) begin
      digit_nxt[i] = digit[i];
      if (clear) begin
        digit_nxt[i] = 4'd0;
      end else if (carry) begin
        if (digit[i] == ((i % 2 == 1) ? 4'd5 : 4'd9)) begin
          digit_nxt[i] = 4'd0;
        end else begin
          digit_nxt[i] = digit[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    changed = 4'd0;
    for (int i = 0; i < 4; i++) changed[i] = (digit_nxt[i] != digit[i]);
  end

  always_comb begin
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dirty[i]) sel_idx = 2'(i);
    end
  end

  assign sel_mask = 4'b0001 << sel_idx;
  assign launch   = (state == IDLE) && (dirty != 4'd0);

  // A change landing on the launch cycle keeps its dirty bit: set beats clear.
  assign dirty_nxt = clear ? 4'hF : ((dirty & ~(launch ? sel_mask : 4'h0)) | changed);

  assign busy = (dirty != 4'd0) | (state == WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '{default: 4'd0};
    end else begin
      digit <= digit_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      dirty         <= 4'hF;
      avm_address   <= '0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      overrun       <= 1'b0;
    end else begin
      dirty <= dirty_nxt;
      if (clear) begin
        overrun <= 1'b0;
      end else if (count_en && ((dirty != 4'd0) || (state == WRITE))) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (launch) begin
            avm_address   <= BASE_ADDR + ADDR_W'(sel_idx) * ADDR_W'(STRIDE);
            avm_writedata <= {24'd0, seg_of(digit[sel_idx])};
            avm_write     <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          avm_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_clock_display_sequencer.sv
// Directed bench for pio_clock_display_sequencer: a seconds-based time model
// predicts each digit write, which a bus monitor pops and compares per beat.
module tb_pio_clock_display_sequencer;

  localparam int ADDR_W = 16;
  localparam int STRIDE = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              tick;
  logic              run;
  logic              clear;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic              busy;
  logic              overrun;

  int compared   = 0;
  int mismatched = 0;

  logic [47:0] exp_q [$];
  logic [7:0]  shadow [4];
  bit          sb_strict = 1'b1;
  int          secs = 0;

  pio_clock_display_sequencer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(16'h0), .STRIDE(STRIDE), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .run(run), .clear(clear),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active-low segment pattern, dp off.
  function automatic logic [7:0] seg_exp(input int v);
    case (v)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int dig(input int s, input int i);
    case (i)
      0: return s % 10;
      1: return (s / 10) % 6;
      2: return (s / 60) % 10;
      default: return s / 600;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      shadow[int'(avm_address) / STRIDE] = avm_writedata[7:0];
      if (sb_strict) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [47:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(avm_address), 32'(e[47:32]));
          check("wr_data", avm_writedata, e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [7:0] seg);
    exp_q.push_back({16'(idx * STRIDE), 24'd0, seg});
  endtask

  task automatic do_tick();
    int old_secs;
    old_secs = secs;
    if (run) secs = (secs + 1) % 3600;
    if (sb_strict) begin
      for (int i = 0; i < 4; i++) begin
        if (dig(secs, i) != dig(old_secs, i)) push_exp(i, seg_exp(dig(secs, i)));
      end
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 32'(busy), 32'd0);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  task automatic wait_write();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (avm_write) break;
    end
    check("write_start", 32'(avm_write), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0; avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_data", avm_writedata, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Post-reset repaint of 00:00.
    push_exp(0, 8'hC0); push_exp(1, 8'hC0); push_exp(2, 8'hC0); push_exp(3, 8'hC0);
    cyc();
    reset_n = 1'b1;
    wait_idle("idle_after_reset");

    run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      do_tick();
      wait_idle("idle_count");
    end
    check("show_00_10_d0", 32'(shadow[0]), 32'hC0);
    check("show_00_10_d1", 32'(shadow[1]), 32'hF9);

    run = 1'b0;
    do_tick();
    wait_idle("idle_run0");

    // clear beats a coincident tick.
    run = 1'b1;
    secs = 0;
    push_exp(0, 8'hC0); push_exp(1, 8'hC0); push_exp(2, 8'hC0); push_exp(3, 8'hC0);
    clear = 1'b1; tick = 1'b1;
    cyc();
    clear = 1'b0; tick = 1'b0;
    wait_idle("idle_clear_tick");
    check("overrun_after_clear_tick", 32'(overrun), 32'd0);

    for (int k = 0; k < 3599; k++) begin
      do_tick();
      wait_idle("idle_to_5959");
    end
    check("show_5959", {shadow[3], shadow[2], shadow[1], shadow[0]}, 32'h92909290);
    do_tick();
    wait_idle("idle_wrap");
    check("show_wrap", {shadow[3], shadow[2], shadow[1], shadow[0]}, 32'hC0C0C0C0);
    check("overrun_none", 32'(overrun), 32'd0);

    // Stalled beat must hold address/data/write steady.
    avm_waitrequest = 1'b1;
    do_tick();
    wait_write();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_addr", 32'(avm_address), 32'h0);
      check("stall_data", avm_writedata, 32'hF9);
      check("stall_write", 32'(avm_write), 32'd1);
    end
    cyc();
    avm_waitrequest = 1'b0;
    wait_idle("idle_stall");

    // Two ticks two cycles apart while the bus is stalled.
    sb_strict = 1'b0;
    avm_waitrequest = 1'b1;
    do_tick();
    cyc();
    do_tick();
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    cyc();
    avm_waitrequest = 1'b0;
    wait_idle("idle_overrun");
    for (int i = 0; i < 4; i++) check("overrun_final_digit", 32'(shadow[i]), 32'(seg_exp(dig(secs, i))));
    check("overrun_final_d0", 32'(shadow[0]), 32'hB0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    sb_strict = 1'b1;

    secs = 0;
    push_exp(0, 8'hC0); push_exp(1, 8'hC0); push_exp(2, 8'hC0); push_exp(3, 8'hC0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);
    wait_idle("idle_clear");

    // Reset in the middle of a stalled beat.
    sb_strict = 1'b0;
    avm_waitrequest = 1'b1;
    do_tick();
    wait_write();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_write", 32'(avm_write), 32'd0);
    secs = 0;
    avm_waitrequest = 1'b0;
    sb_strict = 1'b1;
    push_exp(0, 8'hC0); push_exp(1, 8'hC0); push_exp(2, 8'hC0); push_exp(3, 8'hC0);
    cyc();
    reset_n = 1'b1;
    wait_idle("idle_after_midreset");
    check("show_after_midreset", {shadow[3], shadow[2], shadow[1], shadow[0]}, 32'hC0C0C0C0);
    check("overrun_after_midreset", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
